// File: rtl/scandoubler_ctrl.sv
// Scandoubler mode controller: measures line period, active pixels and lines per
// frame on clk_vid, and switches the scandoubler / HQ2x selects at frame boundaries.
//
// state    | meaning
// NOSIG    | no hsync edge seen for TIMEOUT cycles
// MEASURE  | hsync present, counting consecutive stable frames
// LOCKED   | LOCK_FRAMES stable frames seen, measurements latched and valid

module scandoubler_ctrl #(
   parameter int unsigned LINE_THRESH = 2400,
   parameter int unsigned TOL         = 4,
   parameter int unsigned LOCK_FRAMES = 3,
   parameter int unsigned TIMEOUT     = 65535
) (
   input  logic        clk_vid,
   input  logic        reset_n,
   input  logic        ce_pix,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic        hb_in,
   input  logic        vb_in,
   input  logic [1:0]  sd_mode,
   input  logic        hq2x_req,
   output logic        sd_en,
   output logic        hq2x_en,
   output logic        switch_stb,
   output logic        timing_valid,
   output logic [15:0] line_period,
   output logic [11:0] pix_per_line,
   output logic [11:0] lines_per_frame
);

   typedef enum logic [1:0] {
      ST_NOSIG   = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [1:0] LF = 2'(LOCK_FRAMES);

   state_t      state_q, state_d;
   logic        hs_d_q, vs_d_q;
   logic [15:0] hcnt_q, hcnt_d, hcnt_inc;
   logic [11:0] pcnt_q, pcnt_d, pcnt_next;
   logic [11:0] lcnt_q, lcnt_d, lcnt_next;
   logic [15:0] cur_period_q, cur_period_d, period_now;
   logic [11:0] cur_pix_q, cur_pix_d;
   logic [11:0] cur_lines_q, cur_lines_d;
   logic [15:0] prev_period_q, prev_period_d, period_diff;
   logic [1:0]  stable_cnt_q, stable_cnt_d, stable_inc;
   logic        sd_en_q, sd_en_d, hq2x_en_q, hq2x_en_d;
   logic        switch_stb_q, switch_stb_d;
   logic        timing_valid_q, timing_valid_d;
   logic [15:0] line_period_q, line_period_d;
   logic [11:0] pix_per_line_q, pix_per_line_d;
   logic [11:0] lines_per_frame_q, lines_per_frame_d;
   logic        hs_rise, vs_rise, frame_stable, timeout_hit, lock_now;
   logic        auto_sd, tgt_sd, tgt_hq;

   // Measurement counters; cur_lines_q still holds the previous frame during the compare
   always_comb begin
      hs_rise       = hs_in & ~hs_d_q;
      vs_rise       = vs_in & ~vs_d_q;
      hcnt_inc      = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;
      hcnt_d        = hs_rise ? 16'd0 : hcnt_inc;
      period_now    = hs_rise ? hcnt_inc : cur_period_q;
      cur_period_d  = period_now;
      pcnt_next     = (ce_pix & ~hb_in & ~vb_in & (pcnt_q != 12'hFFF)) ? pcnt_q + 12'd1 : pcnt_q;
      pcnt_d        = hs_rise ? 12'd0 : pcnt_next;
      cur_pix_d     = (hs_rise && (pcnt_next != 12'd0)) ? pcnt_next : cur_pix_q;
      lcnt_next     = (hs_rise && (lcnt_q != 12'hFFF)) ? lcnt_q + 12'd1 : lcnt_q;
      lcnt_d        = vs_rise ? 12'd0 : lcnt_next;
      cur_lines_d   = vs_rise ? lcnt_next : cur_lines_q;
      prev_period_d = vs_rise ? period_now : prev_period_q;
      period_diff   = (period_now >= prev_period_q) ? period_now - prev_period_q
                                                    : prev_period_q - period_now;
      frame_stable  = (lcnt_next == cur_lines_q) && (32'(period_diff) <= TOL);
      timeout_hit   = ~hs_rise & (32'(hcnt_inc) >= TIMEOUT);
      stable_inc    = (stable_cnt_q >= LF) ? stable_cnt_q : stable_cnt_q + 2'd1;
   end

   always_ff @(posedge clk_vid) begin
      if (!reset_n) state_q <= ST_NOSIG;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      stable_cnt_d = stable_cnt_q;
      if (vs_rise) stable_cnt_d = frame_stable ? stable_inc : 2'd0;
      case (state_q)
         ST_NOSIG: begin
            if (hs_rise) begin
               state_d      = ST_MEASURE;
               stable_cnt_d = 2'd0;
            end
         end
         ST_MEASURE: if (vs_rise && (stable_cnt_d >= LF)) state_d = ST_LOCKED;
         ST_LOCKED:  if (vs_rise && !frame_stable) state_d = ST_MEASURE;
         default:    state_d = ST_NOSIG;
      endcase
      if (timeout_hit) begin
         state_d      = ST_NOSIG;
         stable_cnt_d = 2'd0;
      end
   end

   // Auto decision looks at the post-edge state so the locking frame switches at once
   always_comb begin
      lock_now          = (state_q == ST_MEASURE) && (state_d == ST_LOCKED);
      timing_valid_d    = (state_d == ST_LOCKED);
      line_period_d     = lock_now ? period_now : line_period_q;
      pix_per_line_d    = lock_now ? cur_pix_d : pix_per_line_q;
      lines_per_frame_d = lock_now ? lcnt_next : lines_per_frame_q;
      auto_sd           = (state_d == ST_LOCKED) && (32'(line_period_d) > LINE_THRESH);
      tgt_sd            = sd_en_q;
      tgt_hq            = hq2x_en_q;
      case (sd_mode)
         2'd1: begin tgt_sd = 1'b0; tgt_hq = 1'b0; end
         2'd2: begin tgt_sd = 1'b1; tgt_hq = 1'b0; end
         2'd3: begin tgt_sd = 1'b1; tgt_hq = 1'b1; end
         default: begin
            if (state_d == ST_LOCKED) begin
               tgt_sd = auto_sd;
               tgt_hq = auto_sd & hq2x_req;
            end
         end
      endcase
      sd_en_d      = vs_rise ? tgt_sd : sd_en_q;
      hq2x_en_d    = vs_rise ? tgt_hq : hq2x_en_q;
      switch_stb_d = vs_rise & ((tgt_sd != sd_en_q) | (tgt_hq != hq2x_en_q));
   end

   always_ff @(posedge clk_vid) begin
      if (!reset_n) begin
         hs_d_q            <= hs_in;
         vs_d_q            <= vs_in;
         hcnt_q            <= '0;
         pcnt_q            <= '0;
         lcnt_q            <= '0;
         cur_period_q      <= '0;
         cur_pix_q         <= '0;
         cur_lines_q       <= '0;
         prev_period_q     <= '0;
         stable_cnt_q      <= '0;
         sd_en_q           <= 1'b0;
         hq2x_en_q         <= 1'b0;
         switch_stb_q      <= 1'b0;
         timing_valid_q    <= 1'b0;
         line_period_q     <= '0;
         pix_per_line_q    <= '0;
         lines_per_frame_q <= '0;
      end else begin
         hs_d_q            <= hs_in;
         vs_d_q            <= vs_in;
         hcnt_q            <= hcnt_d;
         pcnt_q            <= pcnt_d;
         lcnt_q            <= lcnt_d;
         cur_period_q      <= cur_period_d;
         cur_pix_q         <= cur_pix_d;
         cur_lines_q       <= cur_lines_d;
         prev_period_q     <= prev_period_d;
         stable_cnt_q      <= stable_cnt_d;
         sd_en_q           <= sd_en_d;
         hq2x_en_q         <= hq2x_en_d;
         switch_stb_q      <= switch_stb_d;
         timing_valid_q    <= timing_valid_d;
         line_period_q     <= line_period_d;
         pix_per_line_q    <= pix_per_line_d;
         lines_per_frame_q <= lines_per_frame_d;
      end
   end

   assign sd_en           = sd_en_q;
   assign hq2x_en         = hq2x_en_q;
   assign switch_stb      = switch_stb_q;
   assign timing_valid    = timing_valid_q;
   assign line_period     = line_period_q;
   assign pix_per_line    = pix_per_line_q;
   assign lines_per_frame = lines_per_frame_q;

endmodule

// File: tb/tb_scandoubler_ctrl.sv
// Scoreboard bench for scandoubler_ctrl: randomized video frames, a frame-rule
// reference model, and a monitor that checks every vsync boundary and poll point.

module tb_scandoubler_ctrl;

   localparam int THRESH = 60;
   localparam int TOLR   = 4;
   localparam int LOCKF  = 3;
   localparam int TMO    = 400;

   logic        clk_vid = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce_pix = 1'b0, hs_in = 1'b0, vs_in = 1'b0, hb_in = 1'b0, vb_in = 1'b0;
   logic [1:0]  sd_mode = 2'd0;
   logic        hq2x_req = 1'b0;
   logic        sd_en, hq2x_en, switch_stb, timing_valid;
   logic [15:0] line_period;
   logic [11:0] pix_per_line, lines_per_frame;

   always #5 clk_vid = ~clk_vid;

   scandoubler_ctrl #(
      .LINE_THRESH(THRESH), .TOL(TOLR), .LOCK_FRAMES(LOCKF), .TIMEOUT(TMO)
   ) dut (
      .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix), .hs_in(hs_in),
      .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in), .sd_mode(sd_mode),
      .hq2x_req(hq2x_req), .sd_en(sd_en), .hq2x_en(hq2x_en),
      .switch_stb(switch_stb), .timing_valid(timing_valid),
      .line_period(line_period), .pix_per_line(pix_per_line),
      .lines_per_frame(lines_per_frame)
   );

   typedef struct {
      int kind;  // 1 = vsync boundary, 2 = poll point
      int sd, hq, stb, tv, lp, ppl, lpf;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic poll_req = 1'b0, mon_poll = 1'b0, mon_rise = 1'b0, mon_vs_prev = 1'b0;
   bit   mon_en = 1'b0;

   // reference model state (state: 0 no signal, 1 measuring, 2 locked)
   int m_st, m_cnt, m_prev_lines, m_prev_period, m_cur_period, m_cur_pix;
   int m_lines, m_gap, m_pix, m_sd, m_hq, m_tv, m_lp, m_ppl, m_lpf;
   bit m_hs_prev, m_vs_prev;

   int       chg_line = -1;
   int       rst_line = -1;
   logic [1:0] chg_mode = 2'd0;
   logic     chg_req = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
      end
   endtask

   task automatic push_exp(input int kind);
      exp_t e;
      e.kind = kind; e.sd = m_sd; e.hq = m_hq; e.stb = 0; e.tv = m_tv;
      e.lp = m_lp; e.ppl = m_ppl; e.lpf = m_lpf;
      exp_q.push_back(e);
   endtask

   task automatic model_cycle(input bit rst, input bit hs, input bit vs, input bit hb,
                              input bit vb, input bit ce);
      bit hr, vr, stable;
      int nst, flines, tsd, thq, diff;
      if (rst) begin
         m_st = 0; m_cnt = 0; m_prev_lines = 0; m_prev_period = 0; m_cur_period = 0;
         m_cur_pix = 0; m_lines = 0; m_gap = 0; m_pix = 0; m_sd = 0; m_hq = 0;
         m_tv = 0; m_lp = 0; m_ppl = 0; m_lpf = 0;
         m_hs_prev = hs; m_vs_prev = vs;
         return;
      end
      hr = hs & !m_hs_prev;
      vr = vs & !m_vs_prev;
      m_hs_prev = hs;
      m_vs_prev = vs;
      if (m_gap < 65535) m_gap++;
      if (ce && !hb && !vb && m_pix < 4095) m_pix++;
      if (hr) begin
         m_cur_period = m_gap;
         m_gap = 0;
         if (m_pix != 0) m_cur_pix = m_pix;
         m_pix = 0;
         if (m_lines < 4095) m_lines++;
      end
      stable = 1'b0;
      flines = m_lines;
      if (vr) begin
         diff = m_cur_period - m_prev_period;
         if (diff < 0) diff = -diff;
         stable = (m_lines == m_prev_lines) && (diff <= TOLR);
         m_prev_lines = m_lines;
         m_prev_period = m_cur_period;
         m_lines = 0;
         m_cnt = stable ? ((m_cnt < LOCKF) ? m_cnt + 1 : m_cnt) : 0;
      end
      nst = m_st;
      if (m_st == 0 && hr) begin
         nst = 1; m_cnt = 0;
      end else if (m_st == 1 && vr && m_cnt >= LOCKF) begin
         nst = 2; m_lp = m_cur_period; m_ppl = m_cur_pix; m_lpf = flines;
      end else if (m_st == 2 && vr && !stable) begin
         nst = 1;
      end
      if (!hr && m_gap >= TMO) begin
         nst = 0; m_cnt = 0;
      end
      m_st = nst;
      m_tv = (m_st == 2) ? 1 : 0;
      if (vr) begin
         tsd = m_sd; thq = m_hq;
         case (sd_mode)
            2'd1: begin tsd = 0; thq = 0; end
            2'd2: begin tsd = 1; thq = 0; end
            2'd3: begin tsd = 1; thq = 1; end
            default: if (m_st == 2) begin
               tsd = (m_lp > THRESH) ? 1 : 0;
               thq = (tsd == 1 && hq2x_req) ? 1 : 0;
            end
         endcase
         begin
            exp_t e;
            e.stb = ((tsd != m_sd) || (thq != m_hq)) ? 1 : 0;
            m_sd = tsd; m_hq = thq;
            e.kind = 1; e.sd = m_sd; e.hq = m_hq; e.tv = m_tv;
            e.lp = m_lp; e.ppl = m_ppl; e.lpf = m_lpf;
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic drive_cycle(input bit rst, input bit hs, input bit vs, input bit hb,
                              input bit vb, input bit ce, input bit poll);
      reset_n  = !rst;
      hs_in    = hs;
      vs_in    = vs;
      hb_in    = hb;
      vb_in    = vb;
      ce_pix   = ce;
      poll_req = poll;
      model_cycle(rst, hs, vs, hb, vb, ce);
      if (poll) push_exp(2);
      @(posedge clk_vid);
      #1;
   endtask

   // frame of n lines: first `split` lines at period pa, the rest at pb
   task automatic run_frame(input int pa, input int n, input int pb, input int split);
      int p;
      bit rst;
      for (int l = 0; l < n; l++) begin
         p = (l < split) ? pa : pb;
         for (int c = 0; c < p; c++) begin
            rst = 1'b0;
            if (l == chg_line && c == 30) begin
               sd_mode  = chg_mode;
               hq2x_req = chg_req;
            end
            if (l == rst_line && c == 30) rst = 1'b1;
            drive_cycle(rst, c < 4, l < 2, c < 16, l < 3, 1'($urandom_range(0, 1)), rst);
         end
      end
   endtask

   task automatic frames(input int p, input int n, input int count);
      for (int i = 0; i < count; i++) run_frame(p, n, p, n);
   endtask

   task automatic set_chg(input int line, input logic [1:0] mode, input logic req);
      chg_line = line; chg_mode = mode; chg_req = req;
   endtask

   task automatic pop_check(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard_empty: got no expectation for kind %0d at %0t", kind, $time);
         return;
      end
      e = exp_q.pop_front();
      chk("entry_kind", 32'(kind), 32'(e.kind));
      chk("sd_en", {31'd0, sd_en}, 32'(e.sd));
      chk("hq2x_en", {31'd0, hq2x_en}, 32'(e.hq));
      if (kind == 1) chk("switch_stb", {31'd0, switch_stb}, 32'(e.stb));
      chk("timing_valid", {31'd0, timing_valid}, 32'(e.tv));
      chk("line_period", {16'd0, line_period}, 32'(e.lp));
      chk("pix_per_line", {20'd0, pix_per_line}, 32'(e.ppl));
      chk("lines_per_frame", {20'd0, lines_per_frame}, 32'(e.lpf));
   endtask

   always @(posedge clk_vid) begin
      mon_vs_prev <= vs_in;
      mon_rise    <= reset_n & vs_in & ~mon_vs_prev;
      mon_poll    <= poll_req;
   end

   always @(negedge clk_vid) begin
      if (mon_rise) pop_check(1);
      if (mon_poll) pop_check(2);
      if (mon_en && !mon_rise) chk("switch_stb_idle", {31'd0, switch_stb}, 32'd0);
   end

   initial begin
      int p, n;
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i == 2);
      mon_en = 1'b1;

      // 15 kHz-class source, auto mode with HQ2x requested
      sd_mode = 2'd0; hq2x_req = 1'b1;
      frames(80, 8, 7);

      // switch to 31 kHz-class source mid-frame, then relock
      run_frame(80, 16, 40, 4);
      frames(40, 16, 5);

      // back to 15 kHz, then small jitter that must stay locked
      frames(80, 8, 6);
      for (int i = 0; i < 5; i++) frames(80 + int'($urandom_range(0, 3)), 8, 1);

      // jitter of 6 drops lock, then relock
      frames(86, 8, 1);
      frames(80, 8, 1);
      frames(86, 8, 1);
      frames(80, 8, 5);

      // hsync loss: poll across the timeout, then restart
      for (int i = 0; i < TMO + 60; i++)
         drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), (i % 50) == 49);
      frames(80, 8, 6);

      // forced modes applied only at the next vsync
      set_chg(3, 2'd1, 1'b1); frames(80, 8, 1);
      set_chg(-1, 2'd1, 1'b1); frames(80, 8, 1);
      set_chg(3, 2'd3, 1'b1); frames(80, 8, 2);
      set_chg(3, 2'd2, 1'b1); frames(80, 8, 2);
      set_chg(3, 2'd0, 1'b0); frames(80, 8, 2);
      set_chg(3, 2'd0, 1'b1); frames(80, 8, 2);
      chg_line = -1;

      // one-cycle reset mid-frame while locked, then relock
      rst_line = 4; frames(80, 8, 1); rst_line = -1;
      frames(80, 8, 6);

      // line-period threshold boundary: 61 doubles, 60 does not
      frames(61, 9, 6);
      frames(60, 10, 6);

      // randomized sources with random mode/request changes mid-frame
      for (int b = 0; b < 3; b++) begin
         case ($urandom_range(0, 3))
            0: begin p = 40; n = 16; end
            1: begin p = 80; n = 8; end
            2: begin p = 61; n = 9; end
            default: begin p = 58 + int'($urandom_range(0, 6)); n = 10; end
         endcase
         for (int f = 0; f < 5; f++) begin
            set_chg(($urandom_range(0, 1) == 0) ? -1 : 5, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
            frames(p + int'($urandom_range(0, 2)), n, 1);
         end
      end
      chg_line = -1;

      for (int i = 0; i < 20; i++) drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
